// File: rtl/sat_pkg.sv
// Shared widths, coefficient defaults and the reciprocal table generator.
// Pure constants/functions; no timing or flow-control behaviour of its own.
package sat_pkg;

    localparam int PIX_W_DEF     = 8;
    localparam int INV_W_DEF     = 6;
    localparam int FRAC_W_DEF    = 4;
    localparam int OUT_W_DEF     = 12;
    localparam int DEF_INV_R_DEF = 18;
    localparam int DEF_INV_G_DEF = 19;
    localparam int DEF_INV_B_DEF = 19;

    function automatic int norm_w(input int pix_w, input int inv_w, input int frac_w);
        return pix_w + inv_w - frac_w;
    endfunction

    function automatic int sum_w(input int pix_w, input int inv_w, input int frac_w);
        return norm_w(pix_w, inv_w, frac_w) + 2;
    endfunction

    // Word k of the reciprocal ROM: floor(2^out_w / (k+1)).
    function automatic int recip_word(input int k, input int out_w);
        return (1 << out_w) / (k + 1);
    endfunction

endpackage

// File: rtl/saturation_pipe_if.sv
// Pixel-in / saturation-out beat bus plus coefficient staging port.
// Latency and backpressure are defined by the pipe that uses the slave side.
interface saturation_pipe_if
    import sat_pkg::*;
#(
    parameter int PIX_W  = PIX_W_DEF,
    parameter int INV_W  = INV_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
);
    localparam int SUM_W = sum_w(PIX_W, INV_W, FRAC_W);

    logic [PIX_W-1:0] i_red;
    logic [PIX_W-1:0] i_green;
    logic [PIX_W-1:0] i_blue;
    logic             i_sof;
    logic             i_valid;
    logic             o_ready;
    logic [INV_W-1:0] i_inv_ar;
    logic [INV_W-1:0] i_inv_ag;
    logic [INV_W-1:0] i_inv_ab;
    logic             i_cfg_wr;
    logic             o_valid;
    logic             i_ready;
    logic [OUT_W-1:0] o_sat;
    logic [OUT_W-1:0] o_sda;
    logic [SUM_W-1:0] o_kha;
    logic             o_sof;
    logic [OUT_W-1:0] o_max_sat;

    modport master (
        output i_red, i_green, i_blue, i_sof, i_valid,
        output i_inv_ar, i_inv_ag, i_inv_ab, i_cfg_wr, i_ready,
        input  o_ready, o_valid, o_sat, o_sda, o_kha, o_sof, o_max_sat
    );

    modport slave (
        input  i_red, i_green, i_blue, i_sof, i_valid,
        input  i_inv_ar, i_inv_ag, i_inv_ab, i_cfg_wr, i_ready,
        output o_ready, o_valid, o_sat, o_sda, o_kha, o_sof, o_max_sat
    );

endinterface

// File: rtl/sat_recip_rom.sv
// Reciprocal ROM, word k = floor(2^OUT_W/(k+1)); 1-cycle registered read.
// Read register only advances when i_en is high, so it stalls with the pipe.
module sat_recip_rom
    import sat_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [OUT_W:0]    o_data
);
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int DATA_W = OUT_W + 1;

    logic [DATA_W-1:0] rom [DEPTH];
    logic [DATA_W-1:0] data_q;

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        assign rom[k] = DATA_W'(recip_word(k, OUT_W));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q <= '0;
        end else if (i_en) begin
            data_q <= rom[i_addr];
        end
    end

    assign o_data = data_q;

endmodule

// File: rtl/saturation_pipe.sv
// Dehaze saturation pipe: normalise, min/sum, diff+recip, sat/kha, sda; latency 5.
// One global enable (~o_valid | i_ready) stalls every stage together; o_ready = enable.
module saturation_pipe
    import sat_pkg::*;
#(
    parameter int PIX_W     = PIX_W_DEF,
    parameter int INV_W     = INV_W_DEF,
    parameter int FRAC_W    = FRAC_W_DEF,
    parameter int OUT_W     = OUT_W_DEF,
    parameter int DEF_INV_R = DEF_INV_R_DEF,
    parameter int DEF_INV_G = DEF_INV_G_DEF,
    parameter int DEF_INV_B = DEF_INV_B_DEF
) (
    input logic               i_clk,
    input logic               i_rst_n,
    saturation_pipe_if.slave  bus
);
    localparam int NORM_W = norm_w(PIX_W, INV_W, FRAC_W);
    localparam int SUM_W  = sum_w(PIX_W, INV_W, FRAC_W);
    localparam int MUL_W  = PIX_W + INV_W;
    localparam int DATA_W = OUT_W + 1;
    localparam int PROD_W = SUM_W + DATA_W;
    localparam int SDA_W  = 2 * OUT_W + 1;
    localparam logic [OUT_W-1:0]  SAT_MAX = '1;
    localparam logic [DATA_W-1:0] SDA_K   = '1;

    logic en, acc, load_act, xfer;

    logic [INV_W-1:0] sh_r_q, sh_g_q, sh_b_q;
    logic [INV_W-1:0] act_r_q, act_g_q, act_b_q;
    logic [INV_W-1:0] inv_r, inv_g, inv_b;

    logic              v1_q, v2_q, v3_q, v4_q, v5_q;
    logic              sof1_q, sof2_q, sof3_q, sof4_q, sof5_q;
    logic [NORM_W-1:0] s1_r_q, s1_g_q, s1_b_q;
    logic [NORM_W-1:0] min2_q, min_d;
    logic [SUM_W-1:0]  sum2_q, sum_d;
    logic [SUM_W-1:0]  diff3_q, sum3_q, three_min, diff_d, rom_addr;
    logic [DATA_W-1:0] recip3;
    logic [OUT_W-1:0]  sat4_q, sat5_q, sat_d;
    logic [SUM_W-1:0]  kha4_q, kha5_q, kha_d;
    logic [OUT_W-1:0]  sda5_q, sda_d;
    logic [MUL_W-1:0]  pr, pg, pb;
    logic [PROD_W-1:0] prod4;
    logic [SDA_W-1:0]  sda_prod;
    logic [OUT_W-1:0]  run_max_q, max_q;

    assign en       = ~v5_q | bus.i_ready;
    assign acc      = bus.i_valid & en;
    assign load_act = acc & bus.i_sof;
    assign xfer     = v5_q & bus.i_ready;

    // A sof beat uses the shadow values it is about to load, not the stale active set.
    assign inv_r = load_act ? sh_r_q : act_r_q;
    assign inv_g = load_act ? sh_g_q : act_g_q;
    assign inv_b = load_act ? sh_b_q : act_b_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sh_r_q  <= INV_W'(DEF_INV_R);
            sh_g_q  <= INV_W'(DEF_INV_G);
            sh_b_q  <= INV_W'(DEF_INV_B);
            act_r_q <= INV_W'(DEF_INV_R);
            act_g_q <= INV_W'(DEF_INV_G);
            act_b_q <= INV_W'(DEF_INV_B);
        end else begin
            if (bus.i_cfg_wr) begin
                sh_r_q <= bus.i_inv_ar;
                sh_g_q <= bus.i_inv_ag;
                sh_b_q <= bus.i_inv_ab;
            end
            if (load_act) begin
                act_r_q <= sh_r_q;
                act_g_q <= sh_g_q;
                act_b_q <= sh_b_q;
            end
        end
    end

    assign pr = MUL_W'(bus.i_red)   * MUL_W'(inv_r);
    assign pg = MUL_W'(bus.i_green) * MUL_W'(inv_g);
    assign pb = MUL_W'(bus.i_blue)  * MUL_W'(inv_b);

    always_comb begin
        min_d = s1_r_q;
        if (s1_g_q < min_d) min_d = s1_g_q;
        if (s1_b_q < min_d) min_d = s1_b_q;
    end

    assign sum_d     = SUM_W'(s1_r_q) + SUM_W'(s1_g_q) + SUM_W'(s1_b_q);
    assign three_min = SUM_W'(min2_q) + (SUM_W'(min2_q) << 1);
    assign diff_d    = (sum2_q > three_min) ? (sum2_q - three_min) : '0;
    assign rom_addr  = (sum2_q != '0) ? (sum2_q - SUM_W'(1)) : '0;

    sat_recip_rom #(
        .ADDR_W (SUM_W),
        .OUT_W  (OUT_W)
    ) u_rom (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (en),
        .i_addr  (rom_addr),
        .o_data  (recip3)
    );

    assign prod4 = PROD_W'(diff3_q) * PROD_W'(recip3);

    always_comb begin
        sat_d = OUT_W'(prod4);
        if (prod4 > PROD_W'(SAT_MAX)) sat_d = SAT_MAX;
        if (sum3_q == '0)             sat_d = '0;
    end

    assign kha_d    = sum3_q + (sum3_q >> 2);
    assign sda_prod = SDA_W'(sat4_q) * SDA_W'(SDA_K - DATA_W'(sat4_q));
    assign sda_d    = OUT_W'(sda_prod >> OUT_W);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0; v4_q <= 1'b0; v5_q <= 1'b0;
            sof1_q <= 1'b0; sof2_q <= 1'b0; sof3_q <= 1'b0; sof4_q <= 1'b0; sof5_q <= 1'b0;
            s1_r_q <= '0; s1_g_q <= '0; s1_b_q <= '0;
            min2_q <= '0; sum2_q <= '0;
            diff3_q <= '0; sum3_q <= '0;
            sat4_q <= '0; kha4_q <= '0;
            sat5_q <= '0; kha5_q <= '0; sda5_q <= '0;
        end else if (en) begin
            v1_q    <= bus.i_valid;
            sof1_q  <= bus.i_sof;
            s1_r_q  <= NORM_W'(pr >> FRAC_W);
            s1_g_q  <= NORM_W'(pg >> FRAC_W);
            s1_b_q  <= NORM_W'(pb >> FRAC_W);
            v2_q    <= v1_q;
            sof2_q  <= sof1_q;
            min2_q  <= min_d;
            sum2_q  <= sum_d;
            v3_q    <= v2_q;
            sof3_q  <= sof2_q;
            diff3_q <= diff_d;
            sum3_q  <= sum2_q;
            v4_q    <= v3_q;
            sof4_q  <= sof3_q;
            sat4_q  <= sat_d;
            kha4_q  <= kha_d;
            v5_q    <= v4_q;
            sof5_q  <= sof4_q;
            sat5_q  <= sat4_q;
            kha5_q  <= kha4_q;
            sda5_q  <= sda_d;
        end
    end

    // Running max restarts at each sof beat; the finished frame's peak is published then.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            run_max_q <= '0;
            max_q     <= '0;
        end else if (xfer) begin
            if (sof5_q) begin
                max_q     <= run_max_q;
                run_max_q <= sat5_q;
            end else if (sat5_q > run_max_q) begin
                run_max_q <= sat5_q;
            end
        end
    end

    assign bus.o_ready   = en;
    assign bus.o_valid   = v5_q;
    assign bus.o_sat     = sat5_q;
    assign bus.o_sda     = sda5_q;
    assign bus.o_kha     = kha5_q;
    assign bus.o_sof     = sof5_q;
    assign bus.o_max_sat = max_q;

endmodule

// File: tb/tb_saturation_pipe.sv
// Scoreboard bench for saturation_pipe: directed pixels with hand-computed results.
module tb_saturation_pipe;
    import sat_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    saturation_pipe_if bus ();

    saturation_pipe dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        int id; int sat; int sda; int kha; int sof; int maxv; int lat; int acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   errors   = 0;
    int   checks   = 0;
    int   cyc      = 0;
    int   nid      = 0;
    int   rdy_mode = 0;   // 0: ready high, 1: toggle, 2: ready low

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        bus.i_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       bus.i_ready = 1'b1;
                1:       bus.i_ready = ~bus.i_ready;
                default: bus.i_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every transferred output beat.
    initial begin
        exp_t e;
        bit   pend;
        int   pend_max;
        pend = 1'b0;
        pend_max = 0;
        forever begin
            @(negedge clk);
            if (pend) begin
                chk($sformatf("max_sat[%0d]", e.id), bus.o_max_sat, pend_max);
                pend = 1'b0;
            end
            if (rst_n) begin
                chk("o_ready_rule", bus.o_ready, (!bus.o_valid || bus.i_ready) ? 1 : 0);
                if (bus.o_valid && bus.i_ready) begin
                    if (sb.size() == 0) begin
                        errors++; checks++;
                        $display("FAIL unexpected_output: sat=%0d kha=%0d, expected no beat", bus.o_sat, bus.o_kha);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("no_x[%0d]", e.id),
                            $isunknown({bus.o_sat, bus.o_sda, bus.o_kha, bus.o_sof, bus.o_max_sat}) ? 1 : 0, 0);
                        chk($sformatf("sat[%0d]", e.id), bus.o_sat, e.sat);
                        chk($sformatf("sda[%0d]", e.id), bus.o_sda, e.sda);
                        chk($sformatf("kha[%0d]", e.id), bus.o_kha, e.kha);
                        chk($sformatf("sof[%0d]", e.id), bus.o_sof, e.sof);
                        if (e.lat != 0) chk($sformatf("latency[%0d]", e.id), cyc - e.acc_cyc, 5);
                        if (e.maxv >= 0) begin
                            pend = 1'b1;
                            pend_max = e.maxv;
                        end
                    end
                end
            end
        end
    end

    task automatic send(input int r, input int g, input int b, input bit sof, input bit cfg,
                        input bit push, input int sat, input int sda, input int kha,
                        input int maxv, input bit lat);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        bus.i_red    = PIX_W_DEF'(r);
        bus.i_green  = PIX_W_DEF'(g);
        bus.i_blue   = PIX_W_DEF'(b);
        bus.i_sof    = sof;
        bus.i_cfg_wr = cfg;
        bus.i_valid  = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clk);
            n++;
            if (bus.o_ready) ok = 1'b1;
        end
        if (!ok) begin
            errors++; checks++;
            $display("FAIL accept_timeout: o_ready=0 for %0d cycles, expected 1", n);
        end else if (push) begin
            sb.push_back('{nid, sat, sda, kha, int'(sof), maxv, int'(lat), cyc});
            nid++;
        end
        @(posedge clk); #1;
        bus.i_valid  = 1'b0;
        bus.i_sof    = 1'b0;
        bus.i_cfg_wr = 1'b0;
    endtask

    task automatic set_inv(input int v, input bit pulse);
        bus.i_inv_ar = INV_W_DEF'(v);
        bus.i_inv_ag = INV_W_DEF'(v);
        bus.i_inv_ab = INV_W_DEF'(v);
        if (pulse) begin
            bus.i_cfg_wr = 1'b1;
            @(posedge clk); #1;
            bus.i_cfg_wr = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            errors++; checks++;
            $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb.size());
            sb.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_red = '0; bus.i_green = '0; bus.i_blue = '0;
        bus.i_sof = 1'b0; bus.i_valid = 1'b0; bus.i_cfg_wr = 1'b0;
        bus.i_inv_ar = '0; bus.i_inv_ag = '0; bus.i_inv_ab = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_o_valid", bus.o_valid, 0);
        chk("rst_o_sat", bus.o_sat, 0);
        chk("rst_o_sda", bus.o_sda, 0);
        chk("rst_o_kha", bus.o_kha, 0);
        chk("rst_o_sof", bus.o_sof, 0);
        chk("rst_o_max_sat", bus.o_max_sat, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_o_ready", bus.o_ready, 1);
        @(posedge clk); #1;

        // Reset coefficients 18/19/19
        send(100, 0, 0, 1, 0, 1, 4032, 4094, 140, 0, 1);
        send(0, 100, 0, 0, 0, 1, 4012, 4093, 147, -1, 0);
        drain();

        // Coefficients 16/16/16
        set_inv(16, 1);
        send(100, 100, 100, 1, 0, 1, 0, 0, 375, 4032, 1);
        send(200, 0, 0, 0, 0, 1, 4000, 4092, 250, -1, 0);
        send(120, 60, 30, 0, 0, 1, 2280, 3290, 262, -1, 0);
        send(1, 0, 0, 0, 0, 1, 4095, 4095, 1, -1, 0);
        send(0, 0, 0, 0, 0, 1, 0, 0, 0, -1, 0);

        // Mid-frame staging of 32 stays inactive until the next sof
        set_inv(32, 1);
        send(50, 0, 0, 0, 0, 1, 4050, 4094, 62, -1, 0);
        send(50, 0, 0, 1, 0, 1, 4000, 4092, 125, 4095, 0);
        send(128, 0, 0, 0, 0, 1, 4095, 4095, 320, -1, 0);

        // cfg write coinciding with a sof beat: that beat still loads 32
        set_inv(16, 0);
        send(50, 0, 0, 1, 1, 1, 4000, 4092, 125, 4095, 0);
        send(50, 0, 0, 0, 0, 1, 4000, 4092, 125, -1, 0);
        send(50, 0, 0, 1, 0, 1, 4050, 4094, 62, 4000, 0);

        // Frame peaks 4000 then 0
        send(200, 0, 0, 1, 0, 1, 4000, 4092, 250, 4050, 0);
        send(0, 0, 0, 1, 0, 1, 0, 0, 0, 4000, 0);
        send(100, 100, 100, 1, 0, 1, 0, 0, 375, 0, 0);
        drain();

        // Back-to-back stream under alternating i_ready
        rdy_mode = 1;
        send(200, 0, 0, 0, 0, 1, 4000, 4092, 250, -1, 0);
        send(100, 100, 100, 0, 0, 1, 0, 0, 375, -1, 0);
        send(120, 60, 30, 0, 0, 1, 2280, 3290, 262, -1, 0);
        send(1, 0, 0, 0, 0, 1, 4095, 4095, 1, -1, 0);
        send(50, 0, 0, 0, 0, 1, 4050, 4094, 62, -1, 0);
        send(0, 0, 0, 0, 0, 1, 0, 0, 0, -1, 0);
        drain();

        // Stall the pipe full of beats, then reset mid-frame
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        send(200, 0, 0, 1, 0, 0, 0, 0, 0, -1, 0);
        send(120, 60, 30, 0, 0, 0, 0, 0, 0, -1, 0);
        send(1, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0);
        repeat (8) @(posedge clk);
        #2;
        chk("stall_o_valid", bus.o_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_o_valid", bus.o_valid, 0);
        chk("midrst_o_sat", bus.o_sat, 0);
        chk("midrst_o_max_sat", bus.o_max_sat, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_release_o_ready", bus.o_ready, 1);
        rdy_mode = 0;
        repeat (10) @(posedge clk);
        #1;

        // Coefficients are back to 18/19/19 after reset
        send(100, 0, 0, 1, 0, 1, 4032, 4094, 140, 0, 1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/saturation_pipe.md
SATURATION_PIPE -- requirements
Module: saturation_pipe

Interface
REQ-001 Parameter PIX_W, default 8: bit width of each colour channel.
REQ-002 Parameter INV_W, default 6: bit width of each atmospheric-light reciprocal coefficient.
REQ-003 Parameter FRAC_W, default 4: fractional bits of the coefficients.
REQ-004 Parameter OUT_W, default 12: saturation output width.
REQ-005 Parameters DEF_INV_R/G/B, defaults 18/19/19: coefficient reset values.
REQ-006 Derived widths: NORM_W = PIX_W+INV_W-FRAC_W; SUM_W = NORM_W+2.
REQ-007 Ports, one per line:
- i_clk  in  1  sole clock, all logic on posedge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_red, i_green, i_blue  in  PIX_W each  pixel channels.
- i_sof  in  1  first pixel of a frame.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block accepts an input beat.
- i_inv_ar, i_inv_ag, i_inv_ab  in  INV_W each  coefficients to be staged.
- i_cfg_wr  in  1  stage the coefficients into the shadow registers.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts the output beat.
- o_sat  out  OUT_W  saturation.
- o_sda  out  OUT_W  saturation product term.
- o_kha  out  SUM_W  scaled channel sum.
- o_sof  out  1  i_sof delayed with its pixel.
- o_max_sat  out  OUT_W  maximum saturation of the previous complete frame.

Function
REQ-008 The block SHALL be a 5-stage valid pipeline with one global enable, en = ~o_valid | i_ready; o_ready = en; an input is accepted when i_valid & o_ready.
REQ-009 When en=0, every stage SHALL hold its data and valid bit; no beat is lost or duplicated.
REQ-010 Latency SHALL be exactly 5 enabled cycles from acceptance to o_valid, with throughput 1 beat/cycle while i_ready=1.
REQ-011 i_cfg_wr SHALL write the inputs into shadow registers. The active coefficients SHALL load from the shadow registers only on an accepted beat with i_sof=1, and that beat SHALL use the new values.
REQ-012 Stage 1 SHALL compute sX = (pixel_X * active_inv_X) >> FRAC_W, unsigned, NORM_W bits, exact, for each of R, G and B.
REQ-013 Stage 2 SHALL compute min = min(sr,sg,sb) and sum = sr+sg+sb (SUM_W bits, no overflow).
REQ-014 Stage 3 SHALL compute diff = sum - 3*min, saturated at 0. It SHALL perform a registered ROM read at address (sum>0 ? sum-1 : 0).
REQ-015 ROM word k SHALL be floor(2^OUT_W/(k+1)), OUT_W+1 bits wide.
REQ-016 Stage 4 SHALL compute sat = min(diff*recip, 2^OUT_W-1); sat SHALL be forced to 0 when sum=0.
REQ-017 Stage 4 SHALL compute kha = sum + (sum>>2), truncated to SUM_W bits.
REQ-018 Stage 5 SHALL compute sda = (sat*((2^(OUT_W+1)-1) - sat)) >> OUT_W, truncated to OUT_W bits. sat and kha SHALL be delayed to align with sda.
REQ-019 A frame-max register SHALL track the maximum o_sat of output beats; the transfer rule is o_valid & i_ready.
REQ-020 On a transferred beat with o_sof=1, o_max_sat SHALL take the running maximum (the previous frame's value), and the running maximum SHALL restart at that beat's o_sat.
REQ-021 i_cfg_wr and an accepted sof beat in the same cycle: the sof beat SHALL load the old shadow value; the new value SHALL apply from the next sof.

Reset
REQ-022 Assertion of i_rst_n=0 SHALL asynchronously clear all stage valid bits, o_valid, o_sat, o_sda, o_kha, o_sof, o_max_sat and the running maximum to 0.
REQ-023 Reset SHALL set the shadow and active coefficients to DEF_INV_R/G/B.
REQ-024 Reset mid-frame SHALL discard all in-flight beats. After release, o_ready SHALL be 1 on the first clock edge.

Structure
REQ-025 Package sat_pkg SHALL hold the parameter defaults, the width-derivation constants and the reciprocal-table function.
REQ-026 The reciprocal ROM SHALL be sub-module sat_recip_rom (synchronous read with enable, contents from the sat_pkg function). The rest SHALL be flat.

Verification
REQ-027 Coefficients 16/16/16 and pixel (100,100,100) -> sat=0, sda=0, kha=375, 5 cycles after acceptance.
REQ-028 Coefficients 16/16/16 and pixel (200,0,0) -> sat=4000, sda=4092, kha=250.
REQ-029 Pixel (0,0,0) -> sat=0, sda=0, kha=0, with no X values on any output.
REQ-030 Continuous input with i_ready toggled 1/0 each cycle -> output sequence identical to the input order with no drops or duplicates, and o_ready = ~o_valid | i_ready.
REQ-031 i_cfg_wr with 32/32/32 mid-frame -> coefficients unchanged until the next sof beat. From that beat on, pixel (50,0,0) -> kha = 100+25 = 125.
REQ-032 Two frames with peak sat 4000 then 0, followed by a third sof -> o_max_sat = 4000 after the second sof and 0 after the third. Reset asserted mid-frame -> o_valid=0 within the same cycle.
